decode_stage: RTL
=================

Name: decode_stage

Overview:
- RV32I instruction-decode stage of the 5-stage pipeline.
- Takes the IF/ID instruction, drives the register-file read addresses, and decodes control and immediate.
- Captures register-file read data, immediate, control and PC into the ID/EX pipeline register for the execute stage.
- Detects load-use hazards and inserts bubbles; honours downstream stall and branch flush.

Parameters:
- XLEN, 32, datapath width; only 32 is supported.
- RESET_PC, 32'h0000_0000, value ex_pc_o takes in reset.

Ports:
- clk_i  in  1  clock; all state updates on posedge.
- rst_i  in  1  synchronous, active-high reset.
- valid_i  in  1  IF/ID holds a valid instruction.
- instr_i  in  32  instruction word.
- pc_i  in  32  PC of instr_i.
- stall_i  in  1  downstream stall: hold ID/EX contents.
- flush_i  in  1  branch/jump redirect: kill ID/EX.
- rd1_i  in  32  register-file read data, port 1.
- rd2_i  in  32  register-file read data, port 2.
- a1_o  out  5  rs1 address to register file.
- a2_o  out  5  rs2 address to register file.
- load_use_stall_o  out  1  upstream must hold PC and IF/ID.
- ex_valid_o  out  1  ID/EX holds a live instruction.
- ex_pc_o  out  32  PC of the ID/EX instruction.
- ex_rd1_o  out  32  captured rs1 data.
- ex_rd2_o  out  32  captured rs2 data.
- ex_imm_o  out  32  sign-extended immediate.
- ex_rs1_o, ex_rs2_o, ex_rd_o  out  5 each  register indices, for forwarding.
- ex_alu_op_o  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND, 10 PASSB.
- ex_alu_src_a_o  out  1  0 = rs1, 1 = PC.
- ex_alu_src_b_o  out  1  0 = rs2, 1 = imm.
- ex_result_src_o  out  2  0 = ALU, 1 = memory, 2 = PC+4.
- ex_reg_write_o, ex_mem_read_o, ex_mem_write_o, ex_branch_o, ex_jump_o, ex_jalr_o  out  1 each.
- ex_funct3_o  out  3  branch condition / load-store size.
- ex_illegal_o  out  1  unsupported opcode or funct.

Behaviour:
- Decode is combinational from instr_i. a1_o = instr_i[19:15], a2_o = instr_i[24:20], always driven regardless of valid_i.
- Register-file reads are combinational; rd1_i/rd2_i are sampled in the same cycle as instr_i.
- Immediates by format:
  - I: sext(instr[31:20]).
  - S: sext({instr[31:25], instr[11:7]}).
  - B: sext({instr[31], instr[7], instr[30:25], instr[11:8], 0}).
  - U: {instr[31:12], 12'b0}.
  - J: sext({instr[31], instr[19:12], instr[20], instr[30:21], 0}).
  - R: 0.
- Decoded opcodes: LUI (PASSB, src_b = imm), AUIPC (ADD, src_a = PC), JAL, JALR (result_src = 2, reg_write), BRANCH, LOAD, STORE, OP-IMM, OP.
  - SUB/SRA are selected by instr[30]. SRAI/SRLI are distinguished by instr[30].
- Illegal instruction: any other opcode, or an invalid funct7. Sets ex_illegal_o = 1, forces all write/mem/branch/jump controls to 0, and ex_valid_o stays 1.
- rd == x0: ex_reg_write_o is still asserted; the register file ignores the write.
- ID/EX register update, evaluated at each posedge in this priority order:
  1. rst_i: ex_valid_o = 0, all controls 0, ex_pc_o = RESET_PC, data/imm/index fields 0.
  2. flush_i: ex_valid_o = 0, all controls 0; data fields don't-care.
  3. stall_i: all ID/EX fields hold.
  4. load_use_stall_o: insert a bubble (ex_valid_o = 0, controls 0).
  5. Otherwise capture the decode; ex_valid_o = valid_i. When valid_i = 0, controls are 0.
- load_use_stall_o is combinational and asserts when all of these hold:
  - ex_valid_o and ex_mem_read_o are 1, and ex_rd_o != 0;
  - valid_i is 1;
  - ex_rd_o equals rs1 of an instruction that uses rs1, or rs2 of an instruction that uses rs2 (OP, STORE, BRANCH).
  - LUI, AUIPC and JAL use neither register.
- load_use_stall_o is forced to 0 while flush_i or stall_i is 1.
- A load-use stall lasts exactly 1 cycle: after the bubble, ex_mem_read_o = 0, so the stall deasserts.
- Reset mid-stall clears the bubble state with no residue.

Optional Feature:
- Macro: LOAD_USE_DETECT_EN.
- Defined: load-use detection and bubble insertion exactly as specified above.
- Undefined: load_use_stall_o is tied to 0 and there is no bubble priority step. Software or the compiler guarantees a 1-instruction gap after each load.

Test Plan:
- Reset: rst_i = 1 for 2 cycles → ex_valid_o = 0, ex_reg_write_o = 0, ex_pc_o = RESET_PC, load_use_stall_o = 0.
- addi x5,x0,7 (0x00700293), pc 0x100, rd1_i = 0 → next cycle ex_imm_o = 7, ex_rd_o = 5, alu_op = 0, src_b = 1, reg_write = 1, ex_pc_o = 0x100.
- lw x6,4(x5) (0x0042A303), then add x7,x6,x5 (0x005303B3) → load_use_stall_o = 1 for 1 cycle, then one bubble (ex_valid_o = 0), then the add is captured with ex_rs1_o = 6 and ex_rs2_o = 5.
- beq x1,x2,-8 (0xFE208CE3) → ex_imm_o = 0xFFFFFFF8, ex_branch_o = 1, ex_funct3_o = 0, ex_reg_write_o = 0.
- Hold and flush:
  - stall_i = 1 for 3 cycles with a valid add in ID/EX → all ex_* outputs unchanged.
  - flush_i = 1 together with stall_i → ex_valid_o = 0 (flush wins).
- Illegal: instr_i = 0x00000000, valid_i = 1 → ex_illegal_o = 1, ex_valid_o = 1, reg_write / mem_read / mem_write / branch / jump all 0.

Source files
------------

// File: rtl/decode_stage.sv
// RV32I instruction-decode stage: register-file addressing, control and
// immediate decode, load-use hazard detection and the ID/EX pipeline register.
// Optional feature macro: LOAD_USE_DETECT_EN. When it is defined, a load
// followed by a dependent instruction produces a one-cycle bubble. When it is
// undefined, load_use_stall_o is tied to 0 and software keeps loads spaced.
module decode_stage #(
    parameter int          XLEN     = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            valid_i,
    input  logic [31:0]     instr_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic            stall_i,
    input  logic            flush_i,
    input  logic [XLEN-1:0] rd1_i,
    input  logic [XLEN-1:0] rd2_i,
    output logic [4:0]      a1_o,
    output logic [4:0]      a2_o,
    output logic            load_use_stall_o,
    output logic            ex_valid_o,
    output logic [XLEN-1:0] ex_pc_o,
    output logic [XLEN-1:0] ex_rd1_o,
    output logic [XLEN-1:0] ex_rd2_o,
    output logic [XLEN-1:0] ex_imm_o,
    output logic [4:0]      ex_rs1_o,
    output logic [4:0]      ex_rs2_o,
    output logic [4:0]      ex_rd_o,
    output logic [3:0]      ex_alu_op_o,
    output logic            ex_alu_src_a_o,
    output logic            ex_alu_src_b_o,
    output logic [1:0]      ex_result_src_o,
    output logic            ex_reg_write_o,
    output logic            ex_mem_read_o,
    output logic            ex_mem_write_o,
    output logic            ex_branch_o,
    output logic            ex_jump_o,
    output logic            ex_jalr_o,
    output logic [2:0]      ex_funct3_o,
    output logic            ex_illegal_o
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_PASSB = 4'd10;

    // Every control field that a bubble, flush or reset must clear.
    typedef struct packed {
        logic [3:0] alu_op;
        logic       alu_src_a;
        logic       alu_src_b;
        logic [1:0] result_src;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       jalr;
        logic [2:0] funct3;
        logic       illegal;
    } ctrl_t;

    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [XLEN-1:0] imm_d;
    ctrl_t           ctrl_d;
    ctrl_t           ctrl_q;
    logic            uses_rs1;
    logic            uses_rs2;
    logic            bad_funct7;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];
    assign rs1    = instr_i[19:15];
    assign rs2    = instr_i[24:20];
    assign rd     = instr_i[11:7];
    assign a1_o   = rs1;
    assign a2_o   = rs2;

    // Map funct3 to the ALU operation; alt selects SUB / SRA where allowed.
    function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  alu_from_funct3 = alt ? ALU_SUB : ALU_ADD;
            3'b001:  alu_from_funct3 = 4'd2;
            3'b010:  alu_from_funct3 = 4'd3;
            3'b011:  alu_from_funct3 = 4'd4;
            3'b100:  alu_from_funct3 = 4'd5;
            3'b101:  alu_from_funct3 = alt ? 4'd7 : 4'd6;
            3'b110:  alu_from_funct3 = 4'd8;
            default: alu_from_funct3 = 4'd9;
        endcase
    endfunction

    // Combinational decode of controls, immediate and register usage.
    // JALR raises both jump and jalr so that jump alone marks any redirect.
    always_comb begin
        ctrl_d        = '0;
        ctrl_d.funct3 = funct3;
        imm_d         = '0;
        uses_rs1      = 1'b0;
        uses_rs2      = 1'b0;
        bad_funct7    = 1'b0;
        case (opcode)
            OPC_LUI: begin
                ctrl_d.alu_op    = ALU_PASSB;
                ctrl_d.alu_src_b = 1'b1;
                ctrl_d.reg_write = 1'b1;
                imm_d            = {instr_i[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                ctrl_d.alu_src_a = 1'b1;
                ctrl_d.alu_src_b = 1'b1;
                ctrl_d.reg_write = 1'b1;
                imm_d            = {instr_i[31:12], 12'b0};
            end
            OPC_JAL: begin
                ctrl_d.alu_src_a  = 1'b1;
                ctrl_d.alu_src_b  = 1'b1;
                ctrl_d.result_src = 2'd2;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.jump       = 1'b1;
                imm_d = {{12{instr_i[31]}}, instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
            end
            OPC_JALR: begin
                ctrl_d.alu_src_b  = 1'b1;
                ctrl_d.result_src = 2'd2;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.jump       = 1'b1;
                ctrl_d.jalr       = 1'b1;
                imm_d             = {{20{instr_i[31]}}, instr_i[31:20]};
                uses_rs1          = 1'b1;
            end
            OPC_BRANCH: begin
                ctrl_d.alu_op = ALU_SUB;
                ctrl_d.branch = 1'b1;
                imm_d = {{20{instr_i[31]}}, instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
            end
            OPC_LOAD: begin
                ctrl_d.alu_src_b  = 1'b1;
                ctrl_d.result_src = 2'd1;
                ctrl_d.reg_write  = 1'b1;
                ctrl_d.mem_read   = 1'b1;
                imm_d             = {{20{instr_i[31]}}, instr_i[31:20]};
                uses_rs1          = 1'b1;
            end
            OPC_STORE: begin
                ctrl_d.alu_src_b = 1'b1;
                ctrl_d.mem_write = 1'b1;
                imm_d            = {{20{instr_i[31]}}, instr_i[31:25], instr_i[11:7]};
                uses_rs1         = 1'b1;
                uses_rs2         = 1'b1;
            end
            OPC_OPIMM: begin
                ctrl_d.alu_op    = alu_from_funct3(funct3, (funct3 == 3'b101) && instr_i[30]);
                ctrl_d.alu_src_b = 1'b1;
                ctrl_d.reg_write = 1'b1;
                imm_d            = {{20{instr_i[31]}}, instr_i[31:20]};
                uses_rs1         = 1'b1;
                bad_funct7 = ((funct3 == 3'b001) && (funct7 != 7'b0000000)) ||
                             ((funct3 == 3'b101) && (funct7 != 7'b0000000) && (funct7 != 7'b0100000));
            end
            OPC_OP: begin
                ctrl_d.alu_op    = alu_from_funct3(funct3, instr_i[30]);
                ctrl_d.reg_write = 1'b1;
                uses_rs1         = 1'b1;
                uses_rs2         = 1'b1;
                bad_funct7 = (funct7 != 7'b0000000) &&
                             !((funct7 == 7'b0100000) && ((funct3 == 3'b000) || (funct3 == 3'b101)));
            end
            default: begin
                bad_funct7 = 1'b1;
            end
        endcase
        if (bad_funct7) begin
            ctrl_d         = '0;
            ctrl_d.illegal = 1'b1;
            uses_rs1       = 1'b0;
            uses_rs2       = 1'b0;
        end
    end

`ifdef LOAD_USE_DETECT_EN
    assign load_use_stall_o = ex_valid_o && ctrl_q.mem_read && (ex_rd_o != 5'd0) && valid_i &&
                              !flush_i && !stall_i &&
                              ((uses_rs1 && (ex_rd_o == rs1)) || (uses_rs2 && (ex_rd_o == rs2)));
`else
    assign load_use_stall_o = 1'b0;
`endif

    // ID/EX register: reset, then flush, then hold, then bubble, then capture.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            ex_valid_o <= 1'b0;
            ctrl_q     <= '0;
            ex_pc_o    <= RESET_PC;
            ex_rd1_o   <= '0;
            ex_rd2_o   <= '0;
            ex_imm_o   <= '0;
            ex_rs1_o   <= '0;
            ex_rs2_o   <= '0;
            ex_rd_o    <= '0;
        end else if (flush_i) begin
            ex_valid_o <= 1'b0;
            ctrl_q     <= '0;
        end else if (stall_i) begin
            ex_valid_o <= ex_valid_o;
        end
`ifdef LOAD_USE_DETECT_EN
        else if (load_use_stall_o) begin
            ex_valid_o <= 1'b0;
            ctrl_q     <= '0;
        end
`endif
        else begin
            ex_valid_o <= valid_i;
            ctrl_q     <= valid_i ? ctrl_d : '0;
            ex_pc_o    <= pc_i;
            ex_rd1_o   <= rd1_i;
            ex_rd2_o   <= rd2_i;
            ex_imm_o   <= imm_d;
            ex_rs1_o   <= rs1;
            ex_rs2_o   <= rs2;
            ex_rd_o    <= rd;
        end
    end

    assign ex_alu_op_o     = ctrl_q.alu_op;
    assign ex_alu_src_a_o  = ctrl_q.alu_src_a;
    assign ex_alu_src_b_o  = ctrl_q.alu_src_b;
    assign ex_result_src_o = ctrl_q.result_src;
    assign ex_reg_write_o  = ctrl_q.reg_write;
    assign ex_mem_read_o   = ctrl_q.mem_read;
    assign ex_mem_write_o  = ctrl_q.mem_write;
    assign ex_branch_o     = ctrl_q.branch;
    assign ex_jump_o       = ctrl_q.jump;
    assign ex_jalr_o       = ctrl_q.jalr;
    assign ex_funct3_o     = ctrl_q.funct3;
    assign ex_illegal_o    = ctrl_q.illegal;

endmodule
